// File: rtl/word_byte_sequencer.sv
// Serializes a 32-bit word into bytes over valid/ready, with partial
// lengths, selectable byte order and running byte/word counters.
//
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready/in_data/in_len : word producer side
//   out_valid/out_ready/out_byte/out_last : byte consumer side
//   busy : a word is held
//   byte_cnt/word_cnt : wrapping handshake counters
//   err_len : sticky, a zero-length word was accepted
module word_byte_sequencer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic [2:0]       in_len,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_byte,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic             err_len
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       len_q, len_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;

  logic       hs;
  logic       last_hs;
  logic       acc;
  logic [2:0] len_eff;
  logic [1:0] idx_nx;

  function automatic logic [7:0] lane(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    logic [1:0] s;
    s = MSB_FIRST ? (2'd3 - i) : i;
    case (s)
      2'd3:    lane = w[31:24];
      2'd2:    lane = w[23:16];
      2'd1:    lane = w[15:8];
      default: lane = w[7:0];
    endcase
  endfunction

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_byte  = byte_q;
  assign out_last  = last_q;
  assign byte_cnt  = bcnt_q;
  assign word_cnt  = wcnt_q;
  assign err_len   = err_q;

  assign hs       = out_valid && out_ready;
  assign last_hs  = hs && last_q;
  assign in_ready = reset && ((state_q == IDLE) || last_hs);
  assign acc      = in_valid && in_ready;
  // Lengths above 4 saturate to a full word.
  assign len_eff  = (in_len > 3'd4) ? 3'd4 : in_len;
  assign idx_nx   = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    len_d   = len_q;
    byte_d  = byte_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;

    if (hs) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end
    if (last_hs) begin
      wcnt_d  = wcnt_q + CNT_W'(1);
      state_d = IDLE;
      last_d  = 1'b0;
    end else if (hs) begin
      idx_d  = idx_nx;
      byte_d = lane(word_q, idx_nx);
      last_d = ({1'b0, idx_nx} + 3'd1) == len_q;
    end

    // A new word overrides the idle transition so the next word
    // follows the last byte with no bubble.
    if (acc && (in_len == 3'd0)) begin
      err_d = 1'b1;
    end else if (acc) begin
      state_d = SEND;
      word_d  = in_data;
      idx_d   = 2'd0;
      len_d   = len_eff;
      byte_d  = lane(in_data, 2'd0);
      last_d  = (len_eff == 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_word_byte_sequencer.sv
// Bench for word_byte_sequencer: an MSB-first instance with 16-bit
// counters and an LSB-first instance with 4-bit counters share stimulus.
module tb_word_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [2:0]  in_len;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, busy, err_len;
  logic [7:0]  out_byte;
  logic [15:0] byte_cnt, word_cnt;

  logic        l_in_ready, l_out_valid, l_out_last, l_busy, l_err_len;
  logic [7:0]  l_out_byte;
  logic [3:0]  l_byte_cnt, l_word_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  word_byte_sequencer #(.MSB_FIRST(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_len(in_len),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
    .out_ready(out_ready),
    .busy(busy), .byte_cnt(byte_cnt), .word_cnt(word_cnt),
    .err_len(err_len)
  );

  word_byte_sequencer #(.MSB_FIRST(1'b0), .CNT_W(4)) dut_lsb (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_len(in_len),
    .in_ready(l_in_ready),
    .out_valid(l_out_valid), .out_byte(l_out_byte), .out_last(l_out_last),
    .out_ready(out_ready),
    .busy(l_busy), .byte_cnt(l_byte_cnt), .word_cnt(l_word_cnt),
    .err_len(l_err_len)
  );

  typedef struct packed {
    logic        iv;
    logic [31:0] data;
    logic [2:0]  len;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [7:0]  ob;
    logic        ol;
    logic [7:0]  lob;
    logic [15:0] bc;
    logic [15:0] wc;
    logic        err;
  } vec_t;

  vec_t tbl [40];

  function automatic vec_t v(
    input logic iv, input logic [31:0] data, input logic [2:0] len,
    input logic ordy, input logic ir, input logic ov,
    input logic [7:0] ob, input logic ol, input logic [7:0] lob,
    input logic [15:0] bc, input logic [15:0] wc, input logic err
  );
    vec_t r;
    r.iv = iv; r.data = data; r.len = len; r.ordy = ordy;
    r.ir = ir; r.ov = ov; r.ob = ob; r.ol = ol; r.lob = lob;
    r.bc = bc; r.wc = wc; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    logic [31:0] w;

    // full word, both orders
    tbl[0]  = v(1, 32'h12345678, 4, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 1, 0, 1, 8'h12, 0, 8'h78, 0, 0, 0);
    tbl[2]  = v(0, 0, 0, 1, 0, 1, 8'h34, 0, 8'h56, 1, 0, 0);
    tbl[3]  = v(0, 0, 0, 1, 0, 1, 8'h56, 0, 8'h34, 2, 0, 0);
    tbl[4]  = v(0, 0, 0, 1, 1, 1, 8'h78, 1, 8'h12, 3, 0, 0);
    tbl[5]  = v(0, 0, 0, 1, 1, 0, 8'h78, 0, 8'h12, 4, 1, 0);
    // back-to-back
    tbl[6]  = v(1, 32'hAABBCCDD, 4, 1, 1, 0, 8'h78, 0, 8'h12, 4, 1, 0);
    tbl[7]  = v(1, 32'h11223344, 4, 1, 0, 1, 8'hAA, 0, 8'hDD, 4, 1, 0);
    tbl[8]  = v(1, 32'h11223344, 4, 1, 0, 1, 8'hBB, 0, 8'hCC, 5, 1, 0);
    tbl[9]  = v(1, 32'h11223344, 4, 1, 0, 1, 8'hCC, 0, 8'hBB, 6, 1, 0);
    tbl[10] = v(1, 32'h11223344, 4, 1, 1, 1, 8'hDD, 1, 8'hAA, 7, 1, 0);
    tbl[11] = v(0, 0, 0, 1, 0, 1, 8'h11, 0, 8'h44, 8, 2, 0);
    tbl[12] = v(0, 0, 0, 1, 0, 1, 8'h22, 0, 8'h33, 9, 2, 0);
    tbl[13] = v(0, 0, 0, 1, 0, 1, 8'h33, 0, 8'h22, 10, 2, 0);
    tbl[14] = v(0, 0, 0, 1, 1, 1, 8'h44, 1, 8'h11, 11, 2, 0);
    tbl[15] = v(0, 0, 0, 1, 1, 0, 8'h44, 0, 8'h11, 12, 3, 0);
    // backpressure on the 34 byte
    tbl[16] = v(1, 32'h12345678, 4, 1, 1, 0, 8'h44, 0, 8'h11, 12, 3, 0);
    tbl[17] = v(0, 0, 0, 1, 0, 1, 8'h12, 0, 8'h78, 12, 3, 0);
    tbl[18] = v(0, 0, 0, 0, 0, 1, 8'h34, 0, 8'h56, 13, 3, 0);
    tbl[19] = v(0, 0, 0, 0, 0, 1, 8'h34, 0, 8'h56, 13, 3, 0);
    tbl[20] = v(0, 0, 0, 0, 0, 1, 8'h34, 0, 8'h56, 13, 3, 0);
    tbl[21] = v(0, 0, 0, 1, 0, 1, 8'h34, 0, 8'h56, 13, 3, 0);
    tbl[22] = v(0, 0, 0, 1, 0, 1, 8'h56, 0, 8'h34, 14, 3, 0);
    tbl[23] = v(0, 0, 0, 1, 1, 1, 8'h78, 1, 8'h12, 15, 3, 0);
    tbl[24] = v(0, 0, 0, 1, 1, 0, 8'h78, 0, 8'h12, 16, 4, 0);
    // len 2
    tbl[25] = v(1, 32'h12345678, 2, 1, 1, 0, 8'h78, 0, 8'h12, 16, 4, 0);
    tbl[26] = v(0, 0, 0, 1, 0, 1, 8'h12, 0, 8'h78, 16, 4, 0);
    tbl[27] = v(0, 0, 0, 1, 1, 1, 8'h34, 1, 8'h56, 17, 4, 0);
    tbl[28] = v(0, 0, 0, 1, 1, 0, 8'h34, 0, 8'h56, 18, 5, 0);
    // len 0 from idle
    tbl[29] = v(1, 32'hFFFFFFFF, 0, 1, 1, 0, 8'h34, 0, 8'h56, 18, 5, 0);
    tbl[30] = v(0, 0, 0, 1, 1, 0, 8'h34, 0, 8'h56, 18, 5, 1);
    // len 7 saturates to 4
    tbl[31] = v(1, 32'h12345678, 7, 1, 1, 0, 8'h34, 0, 8'h56, 18, 5, 1);
    tbl[32] = v(0, 0, 0, 1, 0, 1, 8'h12, 0, 8'h78, 18, 5, 1);
    tbl[33] = v(0, 0, 0, 1, 0, 1, 8'h34, 0, 8'h56, 19, 5, 1);
    tbl[34] = v(0, 0, 0, 1, 0, 1, 8'h56, 0, 8'h34, 20, 5, 1);
    tbl[35] = v(0, 0, 0, 1, 1, 1, 8'h78, 1, 8'h12, 21, 5, 1);
    tbl[36] = v(0, 0, 0, 1, 1, 0, 8'h78, 0, 8'h12, 22, 6, 1);
    // len 1, then len 0 offered on its last-byte edge
    tbl[37] = v(1, 32'hA1B2C3D4, 1, 1, 1, 0, 8'h78, 0, 8'h12, 22, 6, 1);
    tbl[38] = v(1, 32'h55555555, 0, 1, 1, 1, 8'hA1, 1, 8'hD4, 22, 6, 1);
    tbl[39] = v(0, 0, 0, 1, 1, 0, 8'hA1, 0, 8'hD4, 23, 7, 1);

    // reset held with a word offered
    reset = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    in_len = 3'd4; out_ready = 1'b1;
    #1;
    chk("rst in_ready0", 32'(in_ready), 0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst in_ready", 32'(in_ready), 0);
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst out_byte", 32'(out_byte), 0);
      chk("rst byte_cnt", 32'(byte_cnt), 0);
      chk("rst word_cnt", 32'(word_cnt), 0);
      chk("rst err_len", 32'(err_len), 0);
      chk("rst busy", 32'(busy), 0);
    end
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel in_ready", 32'(in_ready), 1);
    step();
    chk("rel out_valid", 32'(out_valid), 0);

    for (int i = 0; i < 40; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].data;
      in_len    = tbl[i].len;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("r%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("r%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("r%0d busy", i), 32'(busy), 32'(tbl[i].ov));
      chk($sformatf("r%0d out_byte", i), 32'(out_byte), 32'(tbl[i].ob));
      chk($sformatf("r%0d out_last", i), 32'(out_last), 32'(tbl[i].ol));
      chk($sformatf("r%0d lsb_byte", i), 32'(l_out_byte), 32'(tbl[i].lob));
      chk($sformatf("r%0d byte_cnt", i), 32'(byte_cnt), 32'(tbl[i].bc));
      chk($sformatf("r%0d word_cnt", i), 32'(word_cnt), 32'(tbl[i].wc));
      chk($sformatf("r%0d err_len", i), 32'(err_len), 32'(tbl[i].err));
      step();
    end

    // reset mid-word after 12,34 handshaken
    in_valid = 1'b1; in_data = 32'h12345678; in_len = 3'd4;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid out_byte", 32'(out_byte), 32'h56);
    reset = 1'b0;
    #1;
    chk("mid in_ready", 32'(in_ready), 0);
    step();
    reset = 1'b1;
    #1;
    chk("mid out_valid", 32'(out_valid), 0);
    chk("mid out_byte0", 32'(out_byte), 0);
    chk("mid byte_cnt", 32'(byte_cnt), 0);
    chk("mid word_cnt", 32'(word_cnt), 0);
    chk("mid err_len", 32'(err_len), 0);

    w = 32'hCAFEBABE;
    in_valid = 1'b1; in_data = w; in_len = 3'd4;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cafe b%0d", k), 32'(out_byte),
          32'((w >> (8 * (3 - k))) & 32'hFF));
      chk($sformatf("cafe l%0d", k), 32'(out_last), 32'(k == 3));
      chk($sformatf("cafe v%0d", k), 32'(out_valid), 1);
      step();
    end
    chk("cafe word_cnt", 32'(word_cnt), 1);
    chk("cafe lsb_word", 32'(l_word_cnt), 1);

    // 15 back-to-back single-byte words wrap the 4-bit word counter
    acc = 0;
    in_valid = 1'b1; in_len = 3'd1;
    for (int c = 0; c < 100 && acc < 15; c++) begin
      in_data = 32'(c);
      #1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("wrap accepts", 32'(acc), 15);
    step();
    step();
    chk("wrap lsb_word", 32'(l_word_cnt), 0);
    chk("wrap lsb_byte", 32'(l_byte_cnt), 3);
    chk("wrap word_cnt", 32'(word_cnt), 16);
    chk("wrap byte_cnt", 32'(byte_cnt), 19);
    chk("wrap idle", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_byte_sequencer.md
Name: word_byte_sequencer

Overview:
Sequences a 32-bit word into a byte stream, one byte per handshake, using the same byte slicing as the team's 32-to-4x8 splitter. Byte lanes are O1=[31:24], O2=[23:16], O3=[15:8] and O4=[7:0]. It sits between a word producer (valid/ready) and a byte-wide consumer (valid/ready). It supports partial words, selectable byte order, zero-bubble back-to-back words, and running counters.

Parameters:
MSB_FIRST, 1, 1: emit O1,O2,O3,O4; 0: emit O4,O3,O2,O1
CNT_W, 16, width of byte_cnt and word_cnt

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-low; reset==0 sampled at posedge clears the block
in_valid  input  1  producer has a word
in_data  input  32  word to serialize
in_len  input  3  bytes to emit from this word, counted from the first byte in emission order
in_ready  output  1  word accepted on a cycle where in_valid && in_ready
out_valid  output  1  out_byte is valid
out_byte  output  8  current byte
out_last  output  1  current byte is the last byte of its word
out_ready  input  1  consumer takes byte when out_valid && out_ready
busy  output  1  a word is held (state SEND)
byte_cnt  output  CNT_W  bytes handshaken since reset, wraps to 0
word_cnt  output  CNT_W  words completed (last byte handshaken) since reset, wraps to 0
err_len  output  1  sticky: a word with in_len==0 was accepted

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; out_valid=0, out_byte=8'h00, out_last=0, busy=0.
  - byte_cnt=0, word_cnt=0, err_len=0.
  - Held word and byte index are discarded.
  - in_ready is forced 0 while reset==0.
- States:
  - IDLE: no word held.
  - SEND: word held; out_valid=1.
- in_ready (combinational) = reset && (state==IDLE || (out_valid && out_ready && out_last)).
- Length rules:
  - Effective length L = in_len for values 1..4.
  - in_len 5..7 saturates to L=4.
  - in_len==0: word accepted and discarded, err_len set to 1, state unchanged at IDLE, no counter change.
- Accept with L>=1:
  - At edge T: register word, idx=0.
  - out_byte = lane(idx), out_last=(L==1), out_valid=1, state SEND, all from T+1.
  - Latency from acceptance to first byte: 1 cycle.
- Lane mapping:
  - MSB_FIRST=1: idx0..3 -> [31:24],[23:16],[15:8],[7:0].
  - MSB_FIRST=0: idx0..3 -> [7:0],[15:8],[23:16],[31:24].
- Byte handshake, not last: idx+1; out_byte and out_last update next cycle; byte_cnt+1.
- Byte handshake, last: byte_cnt+1, word_cnt+1.
  - If in_valid with L>=1 on the same edge: next word loaded, its first byte valid next cycle, no bubble.
  - If in_valid with in_len==0 on the same edge: word dropped, err_len=1, go IDLE.
  - Otherwise go IDLE, out_valid=0, out_last=0.
- Backpressure: while out_valid && !out_ready, out_byte, out_last and out_valid are held stable. out_valid never drops without a handshake, except on reset.
- Throughput: 1 byte/cycle sustained with out_ready=1.
- busy = (state==SEND). out_byte retains its last value when idle.
- Counters wrap all-ones -> 0 with no flag. err_len clears only on reset.
- Reset mid-word: the remaining bytes are never emitted. Reset has priority over any simultaneous handshake.

Test Plan:
1. Reset: reset=0 for 2 cycles with in_valid=1 and in_data=32'hDEADBEEF -> in_ready=0, out_valid=0, out_byte=00, byte_cnt=0, word_cnt=0, err_len=0; no word taken after reset rises until in_ready=1.
2. Full word, both orders: in_data=32'h12345678, in_len=4, out_ready=1.
   - MSB_FIRST=1 -> bytes 12,34,56,78 on T+1..T+4, out_last only with 78, in_ready=1 on the 78 cycle, byte_cnt=4, word_cnt=1.
   - MSB_FIRST=0 -> bytes 78,56,34,12.
3. Back-to-back: AABBCCDD then 11223344, in_valid held, out_ready=1 -> 8 consecutive valid cycles AA,BB,CC,DD,11,22,33,44; second word accepted on the DD handshake edge; no bubble; word_cnt=2.
4. Backpressure: out_ready=0 for 3 cycles while 34 is presented -> out_byte=34, out_valid=1, byte_cnt frozen. Then out_ready=1 -> 56 next cycle.
5. Lengths:
   - in_len=2 on 12345678 -> 12,34, out_last on 34.
   - in_len=0 -> no out_valid, err_len=1, counters unchanged.
   - in_len=7 -> 4 bytes.
   - word_cnt preset near wrap (drive 65535 words) -> wraps to 0.
6. Reset mid-word: after 12,34 handshaken, reset=0 for one edge -> out_valid=0, counters 0. Next word CAFEBABE, len 4 -> CA,FE,BA,BE.
